cpu_seq: RTL

- Parametrised program-sequencing unit for the one-cycle CPU; next generation of the PC + jump + link-register path in the control unit.
- Replaces the single link register with a STACK_DEPTH-entry return-address stack.
- Adds conditional jumps, base-relative jumps, an explicit STALL hold and a HALT state.
- Sits between the instruction decoder (drives JMP_MODE/COND/ADDR) and the instruction ROM (addressed by PC_OUT).

---
 rtl/cpu_seq_pkg.sv | 25 ++
 rtl/cpu_seq_if.sv | 29 ++
 rtl/cpu_seq_stack.sv | 59 +++++
 rtl/cpu_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the cpu_seq program-sequencing unit.
// Macro CPU_SEQ_STACK_WRAP_EN makes the return-address stack circular.
package cpu_seq_pkg;

  localparam logic [2:0] NXT  = 3'd0;
  localparam logic [2:0] JMP  = 3'd1;
  localparam logic [2:0] JC   = 3'd2;
  localparam logic [2:0] JREL = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;
  localparam logic [2:0] LDB  = 3'd6;
  localparam logic [2:0] HLT  = 3'd7;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

`ifdef CPU_SEQ_STACK_WRAP_EN
  localparam bit STACK_WRAP = 1'b1;
`else
  localparam bit STACK_WRAP = 1'b0;
`endif

endpackage

// File: rtl/cpu_seq_if.sv
// Decoder/ROM-side bus of cpu_seq. master = decoder, slave = sequencer.
// No handshake: the decoder presents a command every cycle; STALL alone holds the sequencer.
interface cpu_seq_if #(
  parameter int AWIDTH  = 8,
  parameter int SPWIDTH = 3
);
  import cpu_seq_pkg::*;

  logic [2:0]         JMP_MODE;
  logic               COND;
  logic [AWIDTH-1:0]  ADDR;
  logic               STALL;
  logic [AWIDTH-1:0]  PC_OUT;
  logic [SPWIDTH-1:0] SP_OUT;
  logic               HALTED;
  logic               STACK_OVF;
  logic               STACK_UNF;
  seq_state_e         STATE_DBG;

  modport master (
    output JMP_MODE, COND, ADDR, STALL,
    input  PC_OUT, SP_OUT, HALTED, STACK_OVF, STACK_UNF, STATE_DBG
  );

  modport slave (
    input  JMP_MODE, COND, ADDR, STALL,
    output PC_OUT, SP_OUT, HALTED, STACK_OVF, STACK_UNF, STATE_DBG
  );
endinterface

// File: rtl/cpu_seq_stack.sv
// Return-address LIFO kept as a ring buffer with a top pointer and entry count.
// With CPU_SEQ_STACK_WRAP_EN a push on a full stack overwrites the oldest entry.
module cpu_seq_stack #(
  parameter int AWIDTH      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SPWIDTH     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PUSH,
  input  logic               POP,
  input  logic [AWIDTH-1:0]  DIN,
  output logic [AWIDTH-1:0]  DOUT,
  output logic [SPWIDTH-1:0] SP,
  output logic               FULL,
  output logic               EMPTY
);
  import cpu_seq_pkg::*;

  localparam int PW = $clog2(STACK_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(STACK_DEPTH - 1);

  logic [AWIDTH-1:0]  mem_q [STACK_DEPTH];
  logic [PW-1:0]      top_q;   // next slot to write
  logic [SPWIDTH-1:0] sp_q;
  logic               push_ok;
  logic               pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? LAST : p - PW'(1);
  endfunction

  assign FULL    = (sp_q == SPWIDTH'(STACK_DEPTH));
  assign EMPTY   = (sp_q == '0);
  assign push_ok = PUSH && (!FULL || STACK_WRAP);
  assign pop_ok  = POP && !EMPTY;
  assign DOUT    = mem_q[ptr_dec(top_q)];
  assign SP      = sp_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      top_q <= '0;
      sp_q  <= '0;
    end else if (push_ok) begin
      mem_q[top_q] <= DIN;
      top_q        <= ptr_inc(top_q);
      if (!FULL) sp_q <= sp_q + SPWIDTH'(1);
    end else if (pop_ok) begin
      top_q <= ptr_dec(top_q);
      sp_q  <= sp_q - SPWIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_seq.sv
// Program-sequencing unit: PC, base register, return-address stack and RUN/HALT FSM.
// Macro CPU_SEQ_STACK_WRAP_EN selects circular stack behaviour (no overflow flag).
module cpu_seq #(
  parameter int AWIDTH      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SPWIDTH     = $clog2(STACK_DEPTH + 1)
) (
  input  logic     CLK,
  input  logic     RST,
  cpu_seq_if.slave bus
);
  import cpu_seq_pkg::*;

  seq_state_e        state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              push, pop;
  logic [AWIDTH-1:0] stk_dout;
  logic [SPWIDTH-1:0] stk_sp;
  logic              stk_full, stk_empty;
  logic [AWIDTH-1:0] pc_next;

  assign pc_next = pc_q + AWIDTH'(1);

  cpu_seq_stack #(
    .AWIDTH      (AWIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .SPWIDTH     (SPWIDTH)
  ) u_stack (
    .CLK   (CLK),
    .RST   (RST),
    .PUSH  (push),
    .POP   (pop),
    .DIN   (pc_next),
    .DOUT  (stk_dout),
    .SP    (stk_sp),
    .FULL  (stk_full),
    .EMPTY (stk_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Anything other than RUN without STALL leaves every register untouched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    base_d  = base_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_q == RUN && !bus.STALL) begin
      case (bus.JMP_MODE)
        NXT:  pc_d = pc_next;
        JMP:  pc_d = bus.ADDR;
        JC:   pc_d = bus.COND ? bus.ADDR : pc_next;
        JREL: pc_d = base_q + bus.ADDR;
        CALL: begin
          if (!stk_full || STACK_WRAP) begin
            push = 1'b1;
            pc_d = bus.ADDR;
          end else begin
            pc_d  = pc_next;
            ovf_d = 1'b1;
          end
        end
        RET: begin
          if (!stk_empty) begin
            pop  = 1'b1;
            pc_d = stk_dout;
          end else begin
            pc_d  = pc_next;
            unf_d = 1'b1;
          end
        end
        LDB: begin
          base_d = bus.ADDR;
          pc_d   = pc_next;
        end
        HLT:     state_d = HALT;
        default: pc_d = pc_next;
      endcase
    end
  end

  assign bus.PC_OUT    = pc_q;
  assign bus.SP_OUT    = stk_sp;
  assign bus.HALTED    = (state_q == HALT);
  assign bus.STACK_OVF = ovf_q;
  assign bus.STACK_UNF = unf_q;
  assign bus.STATE_DBG = state_q;

endmodule
